// File: rtl/aes_pkg.sv
// Shared widths, core latency and controller state encoding for the AES
// counter-mode feeder.
package aes_pkg;

    localparam int AES_BLOCK_W    = 128;
    localparam int AES_KEY_W      = 128;
    localparam int AES128_LATENCY = 21;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } feeder_state_e;

endpackage

// File: rtl/aes_ks_fifo.sv
// Synchronous show-ahead FIFO holding keystream blocks until the consumer
// accepts them; dout always presents the oldest entry.
module aes_ks_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Credit-limited issue upstream guarantees a slot for every result.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/aes_ctr_feeder.sv
// Counter-mode wrapper around a non-stallable pipelined AES-128 core: issues
// {nonce, ctr} blocks under credit control and buffers results for a consumer.
module aes_ctr_feeder
    import aes_pkg::*;
#(
    parameter int CORE_LATENCY = AES128_LATENCY,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AES_KEY_W-1:0]   key_in,
    input  logic [95:0]            nonce,
    input  logic [31:0]            ctr_init,
    input  logic [15:0]            num_blocks,
    output logic                   busy,
    output logic                   done,
    output logic [AES_BLOCK_W-1:0] core_state,
    output logic [AES_KEY_W-1:0]   core_key,
    input  logic [AES_BLOCK_W-1:0] core_out,
    output logic [AES_BLOCK_W-1:0] ks_data,
    output logic                   ks_valid,
    input  logic                   ks_ready
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          CW1     = CW + 1;
    localparam logic [CW:0] CREDITS = CW1'(FIFO_DEPTH);

    feeder_state_e state, state_nxt;

    logic [95:0]             nonce_q;
    logic [31:0]             ctr_q;
    logic [AES_KEY_W-1:0]    key_q;
    logic [15:0]             remaining;
    logic [CORE_LATENCY-1:0] vld_line;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit_sum;
    logic                    issue;
    logic                    accept;
    logic                    exit_vld;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;

    assign core_state = {nonce_q, ctr_q};
    assign core_key   = key_q;
    assign exit_vld   = vld_line[CORE_LATENCY-1];
    assign ks_valid   = !fifo_empty;
    assign pop        = ks_valid && ks_ready;
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (num_blocks == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = (remaining != '0) && (credit_sum < CREDITS);
                if (issue && remaining == 16'd1) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Look past this cycle's pop so done follows the last pop directly.
                if (inflight == '0 && (fifo_empty || (fifo_count == CW'(1) && pop))) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= '0;
            nonce_q   <= '0;
            ctr_q     <= '0;
            remaining <= '0;
        end else if (accept) begin
            key_q     <= key_in;
            nonce_q   <= nonce;
            ctr_q     <= ctr_init;
            remaining <= num_blocks;
        end else if (issue) begin
            ctr_q     <= ctr_q + 32'd1;
            remaining <= remaining - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_line <= '0;
            inflight <= '0;
        end else begin
            vld_line <= {vld_line[CORE_LATENCY-2:0], issue};
            inflight <= inflight + CW'(issue) - CW'(exit_vld);
        end
    end

    aes_ks_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AES_BLOCK_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (exit_vld),
        .din   (core_out),
        .pop   (pop),
        .dout  (ks_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    a_inflight_matches: assert property (@(posedge clk) disable iff (rst)
        inflight == CW'($countones(vld_line)));

endmodule
